// File: rtl/fmul_arbiter.sv
// rtl/fmul_arbiter.sv - round-robin arbiter sharing one fixed-latency fmul among NREQ requesters
module fmul_arbiter #(
  parameter int NREQ = 2,
  parameter int LAT  = 2,
  parameter int IDW  = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_x1,
  input  logic [32*NREQ-1:0]   req_x2,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_y,
  output logic [31:0]          fm_x1,
  output logic [31:0]          fm_x2,
  input  logic [31:0]          fm_y,
  output logic                 busy
);

  logic [IDW-1:0] r_last;
  logic [LAT-1:0] r_tag_v;
  logic [IDW-1:0] r_tag_id [LAT];

  logic           w_grant_any;
  logic [IDW-1:0] w_grant_id;
  logic [IDW-1:0] w_cand;

  // Walk candidates from farthest to nearest so the nearest after r_last wins.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    w_cand      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = IDW'((int'(r_last) + k) % NREQ);
      if (req_valid[w_cand]) begin
        w_grant_any = 1'b1;
        w_grant_id  = w_cand;
      end
    end
    if (!rstn) begin
      w_grant_any = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = w_grant_any && (w_grant_id == IDW'(i));
    end
  end

  assign fm_x1 = w_grant_any ? req_x1[32*int'(w_grant_id) +: 32] : 32'h0;
  assign fm_x2 = w_grant_any ? req_x2[32*int'(w_grant_id) +: 32] : 32'h0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_last  <= IDW'(NREQ - 1);
      r_tag_v <= '0;
      for (int k = 0; k < LAT; k++) begin
        r_tag_id[k] <= '0;
      end
    end else begin
      if (w_grant_any) begin
        r_last <= w_grant_id;
      end
      r_tag_v[0]  <= w_grant_any;
      r_tag_id[0] <= w_grant_id;
      for (int k = 1; k < LAT; k++) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_id[k] <= r_tag_id[k-1];
      end
    end
  end

  // Last tag stage lines up with fm_y, so the result is routed straight through.
  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      resp_valid[i] = r_tag_v[LAT-1] && (r_tag_id[LAT-1] == IDW'(i));
    end
  end

  assign resp_y = fm_y;
  assign busy   = |r_tag_v;

endmodule

// File: tb/tb_fmul_arbiter.sv
// tb/tb_fmul_arbiter.sv - scoreboard bench for fmul_arbiter with a behavioural 2-cycle fmul
module tb_fmul_arbiter;
  localparam int NREQ = 2;
  localparam int LAT  = 2;
  localparam int IDW  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rstn;
  logic [NREQ-1:0]     req_valid, req_ready, resp_valid;
  logic [32*NREQ-1:0]  req_x1, req_x2;
  logic [31:0]         resp_y, fm_x1, fm_x2, fm_y;
  logic                busy;

  fmul_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_x1(req_x1), .req_x2(req_x2),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_y(resp_y),
    .fm_x1(fm_x1), .fm_x2(fm_x2), .fm_y(fm_y), .busy(busy)
  );

  // Truncating multiply for normal operands; zero operand gives signed zero.
  function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [9:0]  e;
    logic [22:0] f;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'h0 || b[30:0] == 31'h0) return {s, 31'h0};
    m = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (m[47]) begin
      e = e + 10'd1;
      f = m[46:24];
    end else begin
      f = m[45:23];
    end
    return {s, e[7:0], f};
  endfunction

  logic [31:0] p [LAT];
  always @(posedge clk) begin
    p[0] <= fmul_ref(fm_x1, fm_x2);
    for (int k = 1; k < LAT; k++) p[k] <= p[k-1];
  end
  assign fm_y = p[LAT-1];

  typedef struct {
    int          id;
    logic [31:0] y;
    int          due;
  } ent_t;

  ent_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          m_last = NREQ - 1;
  int          waitc [NREQ];
  logic [31:0] op_x1 [NREQ];
  logic [31:0] op_x2 [NREQ];
  bit          g_any;
  int          g_id;
  bit          pend [NREQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_op();
    return {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
  endfunction

  task automatic tick(input bit check_on);
    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] exp_rv;
    logic [31:0]     exp_y;
    logic            exp_busy;
    int              c;
    for (int i = 0; i < NREQ; i++) begin
      req_x1[32*i +: 32] = op_x1[i];
      req_x2[32*i +: 32] = op_x2[i];
    end
    #1;
    g_any = 1'b0;
    g_id  = 0;
    for (int k = NREQ; k >= 1; k--) begin
      c = (m_last + k) % NREQ;
      if (req_valid[c]) begin
        g_any = 1'b1;
        g_id  = c;
      end
    end
    if (!rstn) g_any = 1'b0;
    exp_ready = g_any ? NREQ'(1 << g_id) : '0;
    exp_busy  = (sb.size() != 0);
    exp_rv    = '0;
    exp_y     = 32'h0;
    if (sb.size() != 0 && sb[0].due == cyc) begin
      exp_rv = NREQ'(1 << sb[0].id);
      exp_y  = sb[0].y;
      void'(sb.pop_front());
    end
    if (check_on) begin
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("fm_x1", fm_x1, g_any ? op_x1[g_id] : 32'h0);
      chk("fm_x2", fm_x2, g_any ? op_x2[g_id] : 32'h0);
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (exp_rv != '0) chk("resp_y", resp_y, exp_y);
      for (int i = 0; i < NREQ; i++) begin
        if (rstn && req_valid[i] && !req_ready[i]) waitc[i]++;
        else waitc[i] = 0;
        chk("starve", 32'(waitc[i] <= NREQ - 1), 32'd1);
      end
    end
    if (g_any) begin
      sb.push_back('{id: g_id, y: fmul_ref(op_x1[g_id], op_x2[g_id]), due: cyc + LAT});
      m_last = g_id;
    end
    if (!rstn) begin
      m_last = NREQ - 1;
      sb.delete();
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      op_x1[i] = 32'h0;
      op_x2[i] = 32'h0;
      waitc[i] = 0;
      pend[i]  = 1'b0;
    end
    // T1: reset with both requesters asserting
    rstn = 1'b0;
    req_valid = 2'b11;
    op_x1[0] = 32'h3F800000; op_x2[0] = 32'h40000000;
    op_x1[1] = 32'h40000000; op_x2[1] = 32'h40000000;
    tick(1'b0);
    tick(1'b1);
    rstn = 1'b1;

    // T3: contention from reset pointer -> grants 0,1,0,1
    op_x1[0] = 32'h3FC00000; op_x2[0] = 32'h40000000;
    op_x1[1] = 32'h40000000; op_x2[1] = 32'h40400000;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) tick(1'b1);
    idle(3);

    // T2: single op from requester 0
    op_x1[0] = 32'h40000000; op_x2[0] = 32'h40400000;
    req_valid = 2'b01;
    tick(1'b1);
    idle(3);

    // T4: sole requester 1, three back-to-back ops
    req_valid = 2'b10;
    op_x1[1] = 32'h3F800000; op_x2[1] = 32'h40000000; tick(1'b1);
    op_x1[1] = 32'h40400000; op_x2[1] = 32'h40400000; tick(1'b1);
    op_x1[1] = 32'hC0000000; op_x2[1] = 32'h3FC00000; tick(1'b1);
    idle(3);

    // T5: reset while an op is in flight
    op_x1[0] = 32'h40800000; op_x2[0] = 32'h40000000;
    req_valid = 2'b01;
    tick(1'b1);
    rstn = 1'b0;
    req_valid = 2'b00;
    tick(1'b1);
    rstn = 1'b1;
    idle(3);

    // T6: random traffic, operands held until accepted
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(2, 0) != 0)) begin
          pend[i]  = 1'b1;
          op_x1[i] = rand_op();
          op_x2[i] = rand_op();
        end
        req_valid[i] = pend[i];
      end
      tick(1'b1);
      if (g_any) pend[g_id] = 1'b0;
    end
    idle(LAT + 2);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
